// File: rtl/quad_decoder.sv
// Quadrature (x4) decoder: synchronises and filters the encoder phases, then
// emits registered step/dir pulses, an illegal-transition flag and a wrapping position.
module quad_decoder #(
    parameter int WIDTH  = 8,
    parameter int FILTER = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             clr,
    output logic             step,
    output logic             dir,
    output logic [WIDTH-1:0] pos,
    output logic             err
);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    localparam logic [7:0] FLT_LAST = 8'(FILTER - 1);

    state_t     state, state_nx;
    logic [1:0] init_cnt;
    logic       load;

    logic       a_s1, a_s2, b_s1, b_s2;
    logic       a_f, b_f;
    logic [7:0] a_cnt, b_cnt;
    logic [1:0] prev;
    logic [1:0] cur;
    logic       up_mv, dn_mv, bad;

    function automatic logic [1:0] up_next(input logic [1:0] s);
        logic [1:0] n;
        case (s)
            2'b00:   n = 2'b10;
            2'b10:   n = 2'b11;
            2'b11:   n = 2'b01;
            default: n = 2'b00;
        endcase
        return n;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nx;
            init_cnt <= (state == INIT) ? init_cnt + 2'd1 : '0;
        end
    end

    // INIT waits two edges for the synchronisers, then seeds filters and history on the third
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            INIT: begin
                if (init_cnt == 2'd2) begin
                    state_nx = RUN;
                    load     = 1'b1;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_s1 <= 1'b0;
            a_s2 <= 1'b0;
            b_s1 <= 1'b0;
            b_s2 <= 1'b0;
        end else begin
            a_s1 <= a;
            a_s2 <= a_s1;
            b_s1 <= b;
            b_s2 <= b_s1;
        end
    end

    // A new level is accepted on the FILTER-th consecutive differing cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_f   <= 1'b0;
            b_f   <= 1'b0;
            a_cnt <= '0;
            b_cnt <= '0;
            prev  <= '0;
        end else if (load) begin
            a_f   <= a_s2;
            b_f   <= b_s2;
            a_cnt <= '0;
            b_cnt <= '0;
            prev  <= {a_s2, b_s2};
        end else if (state == RUN) begin
            prev <= {a_f, b_f};
            if (a_s2 == a_f) begin
                a_cnt <= '0;
            end else if (a_cnt == FLT_LAST) begin
                a_f   <= a_s2;
                a_cnt <= '0;
            end else begin
                a_cnt <= a_cnt + 8'd1;
            end
            if (b_s2 == b_f) begin
                b_cnt <= '0;
            end else if (b_cnt == FLT_LAST) begin
                b_f   <= b_s2;
                b_cnt <= '0;
            end else begin
                b_cnt <= b_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        cur   = {a_f, b_f};
        up_mv = 1'b0;
        dn_mv = 1'b0;
        bad   = 1'b0;
        if (state == RUN) begin
            up_mv = (cur == up_next(prev));
            dn_mv = (prev == up_next(cur));
            bad   = ((cur ^ prev) == 2'b11);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step <= 1'b0;
            dir  <= 1'b0;
            err  <= 1'b0;
            pos  <= '0;
        end else begin
            step <= up_mv | dn_mv;
            err  <= bad;
            if (up_mv | dn_mv) begin
                dir <= up_mv;
            end
            if (clr) begin
                pos <= '0;
            end else if (up_mv) begin
                pos <= pos + WIDTH'(1);
            end else if (dn_mv) begin
                pos <= pos - WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Randomised scoreboard bench for quad_decoder: expected step/err events are queued
// at stimulus time and popped by an independent monitor whenever the DUT pulses.
module tb_quad_decoder;

    localparam int F = 3;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         a, b, clr;
    logic         step, dir, err;
    logic [W-1:0] pos;

    quad_decoder #(.WIDTH(W), .FILTER(F)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .clr (clr),
        .step(step),
        .dir (dir),
        .pos (pos),
        .err (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           c;
        bit           e;
        bit           d;
        logic [W-1:0] p;
    } ev_t;

    ev_t          q[$];
    logic [1:0]   lvl;
    bit           mdir;
    logic [W-1:0] mpos;
    int           checks = 0;
    int           errors = 0;
    logic [1:0]   seq[4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    // Position of a phase state along the up-counting Gray cycle
    function automatic int idx(input logic [1:0] s);
        for (int i = 0; i < 4; i++)
            if (seq[i] == s) return i;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a new phase level; optionally assert clr on the edge where its event lands
    task automatic move(input logic [1:0] nv, input int hold, input bit clr_land, input bit expect_it);
        int  d;
        ev_t e;
        d = (idx(nv) - idx(lvl) + 4) % 4;
        if (expect_it && d != 0) begin
            e.c = cyc + 3 + F;
            e.e = (d == 2);
            if (d == 1) begin
                mdir = 1'b1;
                mpos = mpos + 8'd1;
            end else if (d == 3) begin
                mdir = 1'b0;
                mpos = mpos - 8'd1;
            end
            if (clr_land) mpos = '0;
            e.d = mdir;
            e.p = mpos;
            q.push_back(e);
        end else if (clr_land) begin
            mpos = '0;
        end
        lvl    = nv;
        {a, b} = nv;
        for (int i = 1; i <= hold; i++) begin
            clr = (clr_land && i == 3 + F);
            tick();
        end
        clr = 1'b0;
    endtask

    task automatic glitch(input bit on_a, input int len);
        {a, b} = lvl ^ (on_a ? 2'b10 : 2'b01);
        repeat (len) tick();
        {a, b} = lvl;
        repeat (F + 6) tick();
        chk("glitch_a_f", 32'(dut.a_f), 32'(lvl[1]));
        chk("glitch_b_f", 32'(dut.b_f), 32'(lvl[0]));
    endtask

    task automatic quiet_clr();
        clr = 1'b1;
        tick();
        clr  = 1'b0;
        mpos = '0;
        chk("clr_quiet_pos", 32'(pos), 32'(0));
        tick();
    endtask

    function automatic logic [1:0] step_from(input logic [1:0] s, input int d);
        return seq[(idx(s) + d) % 4];
    endfunction

    always @(negedge clk) begin
        ev_t e;
        if (rst === 1'b1 && (step === 1'b1 || err === 1'b1)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got step=%0b err=%0b expected none (cycle %0d)", step, err, cyc);
            end else begin
                e = q.pop_front();
                chk("ev_cycle", 32'(cyc), 32'(e.c));
                chk("ev_step", 32'(step), 32'(!e.e));
                chk("ev_err", 32'(err), 32'(e.e));
                chk("ev_dir", 32'(dir), 32'(e.d));
                chk("ev_pos", 32'(pos), 32'(e.p));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, d;
        rst  = 1'b0;
        a    = 1'b1;
        b    = 1'b1;
        clr  = 1'b0;
        lvl  = 2'b11;
        mpos = '0;
        mdir = 1'b0;
        repeat (3) tick();
        chk("rst_pos", 32'(pos), 32'(0));
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("init_step", 32'(step), 32'(0));
            chk("init_err", 32'(err), 32'(0));
        end
        repeat (10) tick();
        chk("idle_pos", 32'(pos), 32'(0));
        chk("idle_dir", 32'(dir), 32'(0));

        // Wrap below zero and back
        move(2'b10, F + 5, 1'b0, 1'b1);
        chk("wrap_down_pos", 32'(pos), 32'(255));
        chk("wrap_down_dir", 32'(dir), 32'(0));
        move(2'b11, F + 5, 1'b0, 1'b1);
        chk("wrap_up_pos", 32'(pos), 32'(0));

        for (int i = 0; i < 8; i++) move(step_from(lvl, 1), F + 7, 1'b0, 1'b1);
        chk("ups_pos", 32'(pos), 32'(8));
        chk("ups_dir", 32'(dir), 32'(1));

        move(step_from(lvl, 2), F + 6, 1'b0, 1'b1);
        chk("err_pos", 32'(pos), 32'(8));
        chk("err_dir", 32'(dir), 32'(1));

        move(step_from(lvl, 1), F + 6, 1'b1, 1'b1);
        chk("clr_land_pos", 32'(pos), 32'(0));

        glitch(1'b1, 1);
        glitch(1'b1, 2);
        glitch(1'b0, 2);
        quiet_clr();

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            d = (r < 4) ? 1 : (r < 8) ? 3 : 2;
            move(step_from(lvl, d), $urandom_range(F + 4, F + 9), ($urandom % 8) == 0, 1'b1);
            if (($urandom % 8) == 0) glitch($urandom % 2 == 0, $urandom_range(1, F - 1));
            if (($urandom % 10) == 0) quiet_clr();
        end
        chk("rand_pos", 32'(pos), 32'(mpos));

        // Asynchronous reset while a filter count is pending
        quiet_clr();
        move(step_from(lvl, 1), F + 5, 1'b0, 1'b1);
        move(step_from(lvl, 1), F + 5, 1'b0, 1'b1);
        lvl    = step_from(lvl, 1);
        {a, b} = lvl;
        repeat (3) tick();
        #2 rst = 1'b0;
        #1;
        chk("midrst_pos", 32'(pos), 32'(0));
        chk("midrst_dir", 32'(dir), 32'(0));
        chk("midrst_step", 32'(step), 32'(0));
        chk("midrst_err", 32'(err), 32'(0));
        mpos = '0;
        mdir = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        repeat (6) tick();
        chk("post_rst_pos", 32'(pos), 32'(0));
        move(step_from(lvl, 1), F + 6, 1'b0, 1'b1);
        chk("post_rst_step_pos", 32'(pos), 32'(1));
        repeat (F + 6) tick();
        chk("queue_empty", 32'(q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
# quad_decoder

Quadrature decoder feeding the team's up/down position counting: takes the two raw, asynchronous phase inputs (A/B) from an incremental encoder, synchronises and glitch-filters them, and decodes every valid edge into a one-cycle step pulse with direction. It also maintains a wrapping position count. It sits between the encoder pins and any logic that consumes step/direction (x4 decoding).

## Interface
- `WIDTH`, 8: width of position count `pos`.
- `FILTER`, 3: cycles a synchronised phase input must hold a new level before it is accepted; legal range 1..255.

- `clk`, in, 1: clock; all logic on rising edge.
- `rst`, in, 1: reset, asynchronous, active-low (low = reset).
- `a`, in, 1: encoder phase A, asynchronous to `clk`.
- `b`, in, 1: encoder phase B, asynchronous to `clk`.
- `clr`, in, 1: synchronous clear of `pos`.
- `step`, out, 1: one-cycle pulse per accepted valid quadrature transition.
- `dir`, out, 1: direction of last valid step (1 = up, 0 = down); held between steps.
- `pos`, out, WIDTH: position count, +1 per up step, -1 per down step.
- `err`, out, 1: one-cycle pulse on an illegal transition (both phases change in the same accepted cycle).

## Operation
- Synchroniser: two flops per phase (`a_s1`→`a_s2`, likewise b).
- Filter, per phase: counter of consecutive cycles with `x_s2 != x_f`. It resets to 0 whenever they are equal. When it reaches FILTER, `x_f <= x_s2` and the counter clears. The filter counter is wide enough for 255.
- State machine:
  - `INIT`: entered on reset. Waits 2 edges for the synchronisers to fill, then loads `a_f`/`b_f` directly from `a_s2`/`b_s2`, records them as the previous state, and moves to `RUN`. No `step` or `err` is produced in `INIT`.
  - `RUN`: each cycle compares the current {a_f,b_f} with the previous {a_f,b_f} and then updates the previous register.
- Decode, with state written {a_f,b_f}:
  - Up sequence: 00→10→11→01→00.
  - Down sequence: the reverse.
  - No change: nothing.
  - Single-bit change in the up order: `step`=1, `dir`=1, `pos`+1.
  - Single-bit change in the down order: `step`=1, `dir`=0, `pos`-1.
  - Both bits changed: `err`=1, no step, `pos` and `dir` unchanged.
- Arithmetic: `pos` is unsigned modulo 2^WIDTH. All-ones +1 = 0; 0 -1 = all-ones. No saturation, no flag.
- `clr`: sets `pos` to 0 on the next edge and has priority over a coincident step. `step`/`dir` still report that step; `err` is unaffected.
- `clr` in `INIT`: clears `pos`; has no other effect.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). A pending filter count is discarded.

## Timing
- Reset values: `step`=0, `dir`=0, `pos`=0, `err`=0, state=`INIT`, synchronisers/filters/previous state=0, filter counters=0.
- `step`, `dir`, `pos` and `err` are all registered outputs.
- Latency: an input level change first captured at edge E0, and held, is accepted into `x_f` at edge E0+1+FILTER.
- `step`/`err`/`pos`/`dir` update at edge E0+2+FILTER.
- `step`/`err` are high for exactly one cycle per event.
- Pulses shorter than FILTER cycles at `x_s2` are rejected entirely.
- Maximum decodable rate: one phase edge per FILTER+1 cycles, per phase.
- Opposite phases changing in the same cycle of `x_f` is an error, regardless of filter history.
- `RUN` is entered at the 3rd edge after reset release. The first decode is possible at the 4th edge.

## Test plan
- Reset then `a`=`b`=1 held:
  - No `step`/`err`.
  - `pos`=0, `dir`=0 after `INIT`.
  - Previous state = 11.
- FILTER=3, drive 8 up transitions (00→10→11→01→00 ×2), each held 10 cycles:
  - 8 `step` pulses, `dir`=1.
  - `pos`=8.
  - Each pulse 5 edges after the input edge.
- From `pos`=0, one down transition (00→01):
  - `pos`=255 (WIDTH=8), `dir`=0.
  - Then one up transition → `pos`=0.
- Glitch on `a` lasting 2 cycles with FILTER=3:
  - No `step`, no `err`.
  - `a_f` unchanged.
- `a` and `b` toggle together 00→11:
  - `err` pulses once.
  - `pos` and `dir` unchanged, no `step`.
- `clr` asserted in the same cycle an up step lands (`pos`=5):
  - Next `pos`=0, `step`=1, `dir`=1.
  - Assert `rst` low mid-filter: all outputs 0 immediately; state `INIT` on release.
